// File: rtl/spi_master.sv
// Single-lane SPI mode-0 initiator with a byte-wide valid/ready command port.
// Chip select is framed by a per-byte last flag; the divider is frozen per frame.
module spi_master #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [7:0]           tx_data,
    input  logic                 tx_last,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic                 busy,
    output logic                 sck,
    output logic                 cs_n,
    output logic [3:0]           dq_o,
    output logic [3:0]           dq_t,
    input  logic [3:0]           dq_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD,
        ST_GUARD
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           hcnt_q, hcnt_d;
    logic [7:0]           tx_sh_q, tx_sh_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic                 last_q, last_d;
    logic                 sck_q, sck_d;
    logic                 cs_n_q, cs_n_d;
    logic                 mosi_q, mosi_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q, busy_d;

    logic cnt_zero;
    logic accept;
    logic unused_dq_i;

    assign cnt_zero    = (cnt_q == '0);
    assign accept      = tx_valid && tx_ready_q;
    assign unused_dq_i = ^{dq_i[3:2], dq_i[0]};

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        hcnt_d     = hcnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        last_d     = last_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    div_d      = cfg_div;
                    cnt_d      = cfg_div;
                    tx_sh_d    = tx_data;
                    mosi_d     = tx_data[7];
                    last_d     = tx_last;
                    cs_n_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // leaving SETUP is the first rising sck edge, so MISO is sampled here too
                if (cnt_zero) begin
                    sck_d   = 1'b1;
                    cnt_d   = div_q;
                    hcnt_d  = 4'd0;
                    rx_sh_d = {rx_sh_q[6:0], dq_i[1]};
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d  = div_q;
                    hcnt_d = hcnt_q + 4'd1;
                    sck_d  = ~sck_q;
                    if (!sck_q) begin
                        rx_sh_d = {rx_sh_q[6:0], dq_i[1]};
                    end else if (hcnt_q == 4'd14) begin
                        // eighth falling edge: byte complete, mosi keeps its last bit
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        if (last_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            tx_ready_d = 1'b1;
                            state_d    = ST_WAIT;
                        end
                    end else begin
                        mosi_d  = tx_sh_q[6];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    cnt_d      = div_q;
                    tx_sh_d    = tx_data;
                    mosi_d     = tx_data[7];
                    last_d     = tx_last;
                    tx_ready_d = 1'b0;
                    state_d    = ST_SETUP;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = div_q;
                    state_d = ST_GUARD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_zero) begin
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            hcnt_q     <= 4'd0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sck      = sck_q;
    assign cs_n     = cs_n_q;
    assign dq_o     = {3'b000, mosi_q};
    assign dq_t     = 4'b1110;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a mode-0 responder model on dq_i[1] plus
// negedge monitors that timestamp sck, cs_n, tx_ready and rx_valid events.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, busy, sck, cs_n;
    logic [7:0] rx_data;
    logic [3:0] dq_o, dq_t, dq_i;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    spi_master #(.DIV_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_div  (cfg_div),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sck      (sck),
        .cs_n     (cs_n),
        .dq_o     (dq_o),
        .dq_t     (dq_t),
        .dq_i     (dq_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder: presents bit 7 at cs_n fall, next bit after each sck fall
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] bit_sel = 3'd7;
    logic       slave_bit;
    assign slave_bit = slave_byte[bit_sel];
    assign dq_i = {2'b10, slave_bit, ~slave_bit};

    int         rx_cnt = 0, rx_last_cyc = 0, rx_prev_cyc = 0;
    logic [7:0] rx_byte = 8'h00, rx_prev_byte = 8'h00;
    int         cs_fall_cyc = 0, cs_rise_cyc = 0, cs_rise_cnt = 0, cs_high_len = 0;
    int         first_rise = 0, last_rise = 0, last_fall = 0, tr_rise_cyc = 0;
    bit         rise_seen = 1'b0, fall_seen = 1'b0;
    int         hi_min = 0, hi_max = 0, lo_max = 0;
    logic [15:0] mosi_sh = 16'h0000;
    logic       cs_prev = 1'b1, sck_prev = 1'b0, tr_prev = 1'b1;

    always @(negedge clk) begin
        cs_prev  <= cs_n;
        sck_prev <= sck;
        tr_prev  <= tx_ready;
        if (rx_valid) begin
            rx_cnt       <= rx_cnt + 1;
            rx_prev_cyc  <= rx_last_cyc;
            rx_last_cyc  <= cyc;
            rx_prev_byte <= rx_byte;
            rx_byte      <= rx_data;
        end
        if (!cs_n && cs_prev) begin
            cs_fall_cyc <= cyc;
            cs_high_len <= cyc - cs_rise_cyc;
            rise_seen   <= 1'b0;
            fall_seen   <= 1'b0;
            hi_min      <= 9999;
            hi_max      <= 0;
            lo_max      <= 0;
            bit_sel     <= 3'd7;
        end
        if (cs_n && !cs_prev) begin
            cs_rise_cyc <= cyc;
            cs_rise_cnt <= cs_rise_cnt + 1;
        end
        if (tx_ready && !tr_prev) tr_rise_cyc <= cyc;
        if (sck && !sck_prev) begin
            if (!rise_seen) begin
                first_rise <= cyc;
                rise_seen  <= 1'b1;
            end
            if (fall_seen && (cyc - last_fall) > lo_max) lo_max <= cyc - last_fall;
            last_rise <= cyc;
            mosi_sh   <= {mosi_sh[14:0], dq_o[0]};
        end
        if (!sck && sck_prev) begin
            if ((cyc - last_rise) < hi_min) hi_min <= cyc - last_rise;
            if ((cyc - last_rise) > hi_max) hi_max <= cyc - last_rise;
            last_fall <= cyc;
            fall_seen <= 1'b1;
            bit_sel   <= bit_sel - 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // called just after a negedge; returns the cycle in which the byte is accepted
    task automatic send(input logic [7:0] d, input logic l, input bit hold, output int acc);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("accept_in_time", (acc >= 0) ? 1 : 0, 1);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_in_time", ok ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc, acc2, base, cr, bad;
        bit  ok;

        repeat (3) @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_dq_o", dq_o, 4'b0000);
        chk("rst_dq_t", dq_t, 4'b1110);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte, H=1
        cfg_div = 8'd0;
        slave_byte = 8'h3C;
        base = rx_cnt;
        send(8'hA5, 1'b1, 1'b0, acc);
        wait_idle(200);
        chk("h1_mosi", mosi_sh[7:0], 8'hA5);
        chk("h1_rx_data", rx_byte, 8'h3C);
        chk("h1_rx_lat", rx_last_cyc - acc, 17);
        chk("h1_rx_cnt", rx_cnt - base, 1);
        chk("h1_cs_fall", cs_fall_cyc - acc, 1);
        chk("h1_first_rise", first_rise - acc, 2);
        chk("h1_cs_rise", cs_rise_cyc - acc, 18);
        chk("h1_ready_back", tr_rise_cyc - acc, 19);

        // two-byte frame, H=3, tx_valid held high
        cfg_div = 8'd2;
        slave_byte = 8'h5A;
        base = rx_cnt;
        cr = cs_rise_cnt;
        send(8'h9F, 1'b0, 1'b1, acc);
        send(8'h00, 1'b1, 1'b0, acc2);
        wait_idle(400);
        chk("h3_accept_gap", acc2 - acc, 49);
        chk("h3_rx_cnt", rx_cnt - base, 2);
        chk("h3_rx_spacing", rx_last_cyc - rx_prev_cyc, 49);
        chk("h3_sck_low_gap", lo_max, 4);
        chk("h3_hi_min", hi_min, 3);
        chk("h3_hi_max", hi_max, 3);
        chk("h3_cs_one_rise", cs_rise_cnt - cr, 1);
        chk("h3_mosi", mosi_sh, 16'h9F00);
        chk("h3_rx_first", rx_prev_byte, 8'h5A);
        chk("h3_rx_second", rx_byte, 8'h5A);
        chk("h3_cs_rise", cs_rise_cyc - acc2, 52);

        // stall in WAIT, H=1
        cfg_div = 8'd0;
        slave_byte = 8'hC3;
        base = rx_cnt;
        send(8'h01, 1'b0, 1'b0, acc);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_cnt == base + 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stall_first_rx", ok ? 1 : 0, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs_n !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        chk("stall_hold", bad, 0);
        chk("stall_busy", busy, 1);
        send(8'h02, 1'b1, 1'b0, acc2);
        wait_idle(200);
        chk("stall_rx_cnt", rx_cnt - base, 2);
        chk("stall_mosi", mosi_sh, 16'h0102);
        chk("stall_rx_data", rx_byte, 8'hC3);
        chk("stall_cs_rise", cs_rise_cyc - acc2, 18);

        // divider frozen for the frame, H=2 then H=6
        cfg_div = 8'd1;
        slave_byte = 8'h96;
        send(8'h55, 1'b1, 1'b0, acc);
        repeat (4) @(negedge clk);
        cfg_div = 8'd5;
        wait_idle(400);
        chk("frz_hi_min", hi_min, 2);
        chk("frz_hi_max", hi_max, 2);
        chk("frz_lo_max", lo_max, 2);
        chk("frz_rx_lat", rx_last_cyc - acc, 33);
        chk("frz_cs_rise", cs_rise_cyc - acc, 35);
        send(8'h3A, 1'b1, 1'b0, acc);
        wait_idle(400);
        chk("h6_hi_min", hi_min, 6);
        chk("h6_hi_max", hi_max, 6);
        chk("h6_first_rise", first_rise - acc, 7);
        chk("h6_rx_lat", rx_last_cyc - acc, 97);
        chk("h6_cs_rise", cs_rise_cyc - acc, 103);
        chk("h6_rx_data", rx_byte, 8'h96);

        // guard time between back-to-back frames, H=3
        cfg_div = 8'd2;
        send(8'hAA, 1'b1, 1'b1, acc);
        send(8'hBB, 1'b1, 1'b0, acc2);
        wait_idle(400);
        chk("grd_accept_gap", acc2 - acc, 55);
        chk("grd_cs_high", cs_high_len, 4);
        chk("grd_cs_rise", cs_rise_cyc - acc2, 52);

        // asynchronous reset while sck is high in SHIFT, H=4
        cfg_div = 8'd3;
        slave_byte = 8'hFF;
        base = rx_cnt;
        send(8'hFF, 1'b1, 1'b0, acc);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sck) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_sck_high", ok ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sck", sck, 0);
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_dq_o", dq_o, 4'b0000);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_no_rx", rx_cnt - base, 0);
        chk("post_rst_cs_n", cs_n, 1);
        chk("post_rst_ready", tx_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
